// File: rtl/fetch_buffer.sv
// First-word-fall-through {pc, inst} queue between IF and ID.
// Stalls the PC when full and drops every entry on a branch flush.
module fetch_buffer #(
  parameter int          DEPTH    = 2,
  parameter int          PTR_W    = $clog2(DEPTH),
  parameter logic [31:0] NOP_INST = 32'h03400000
) (
  input  logic             fb_clk,
  input  logic             fb_rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  output logic             stop,
  input  logic             flush,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               push, pop;
  entry_t             head;

  // stop comes only from registered occupancy, keeping the PC stall path short
  assign stop      = (count_q == FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid & ~stop & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign head     = mem_q[rd_ptr_q];
  assign out_pc   = out_valid ? head.pc   : 32'h0;
  assign out_inst = out_valid ? head.inst : NOP_INST;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge fb_clk or negedge fb_rst_n) begin
    if (!fb_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the queue is empty
  always_ff @(posedge fb_clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: in_pc, inst: in_inst};
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Random + directed bench for fetch_buffer; DEPTH=2 and DEPTH=4 instances share
// stimulus and are each checked against a queue-based reference model.
module tb_fetch_buffer;

  logic        fb_clk = 1'b0;
  logic        fb_rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_pc = '0, in_inst = '0;

  logic        stop2, ov2, stop4, ov4;
  logic [31:0] opc2, oin2, opc4, oin4;
  logic [1:0]  cnt2;
  logic [2:0]  cnt4;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t m2[$];
  ent_t m4[$];

  localparam logic [31:0] NOP = 32'h03400000;

  fetch_buffer #(.DEPTH(2)) u_dut2 (
    .fb_clk(fb_clk), .fb_rst_n(fb_rst_n), .in_valid(in_valid), .in_pc(in_pc),
    .in_inst(in_inst), .stop(stop2), .flush(flush), .out_valid(ov2),
    .out_pc(opc2), .out_inst(oin2), .out_ready(out_ready), .count(cnt2));

  fetch_buffer #(.DEPTH(4)) u_dut4 (
    .fb_clk(fb_clk), .fb_rst_n(fb_rst_n), .in_valid(in_valid), .in_pc(in_pc),
    .in_inst(in_inst), .stop(stop4), .flush(flush), .out_valid(ov4),
    .out_pc(opc4), .out_inst(oin4), .out_ready(out_ready), .count(cnt4));

  always #5 fb_clk = ~fb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cnt2",  32'(cnt2), 32'(m2.size()));
    chk("ov2",   32'(ov2),  32'(m2.size() != 0));
    chk("stop2", 32'(stop2), 32'(m2.size() == 2));
    chk("pc2",   opc2, (m2.size() != 0) ? m2[0].pc   : 32'h0);
    chk("inst2", oin2, (m2.size() != 0) ? m2[0].inst : NOP);
    chk("cnt4",  32'(cnt4), 32'(m4.size()));
    chk("ov4",   32'(ov4),  32'(m4.size() != 0));
    chk("stop4", 32'(stop4), 32'(m4.size() == 4));
    chk("pc4",   opc4, (m4.size() != 0) ? m4[0].pc   : 32'h0);
    chk("inst4", oin4, (m4.size() != 0) ? m4[0].inst : NOP);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = rdy;
    flush     = fl;
  endtask

  // One clock: decide model push/pop from current inputs, clock, update, check.
  task automatic step();
    bit push2, pop2, push4, pop4, live;
    ent_t e;
    live  = (fb_rst_n === 1'b1);
    e.pc  = in_pc;
    e.inst = in_inst;
    push2 = in_valid && (m2.size() != 2) && !flush;
    pop2  = (m2.size() != 0) && out_ready && !flush;
    push4 = in_valid && (m4.size() != 4) && !flush;
    pop4  = (m4.size() != 0) && out_ready && !flush;
    @(posedge fb_clk);
    if (live) begin
      if (flush) begin
        m2.delete();
        m4.delete();
      end else begin
        if (pop2)  void'(m2.pop_front());
        if (push2) m2.push_back(e);
        if (pop4)  void'(m4.pop_front());
        if (push4) m4.push_back(e);
      end
    end
    #1;
    check_all();
  endtask

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  initial begin
    logic [31:0] exp_out;

    // Reset held for 3 cycles
    fb_rst_n = 1'b0;
    repeat (3) @(posedge fb_clk);
    #1;
    check_all();
    chk("rst_inst", oin2, 32'h03400000);
    chk("rst_pc",   opc2, 32'h0);
    chk("rst_stop", 32'(stop2), 32'h0);
    fb_rst_n = 1'b1;

    // Fill DEPTH=2, blocked push at 0x8, then drain
    drive(1, 32'h0, ins(32'h0), 0, 0); step();
    drive(1, 32'h4, ins(32'h4), 0, 0); step();
    chk("fill_cnt",  32'(cnt2),  32'd2);
    chk("fill_stop", 32'(stop2), 32'd1);
    drive(1, 32'h8, ins(32'h8), 0, 0); step();
    chk("full_hold_cnt", 32'(cnt2), 32'd2);
    chk("full_hold_pc",  opc2, 32'h0);
    drive(0, 32'h0, 32'h0, 1, 0); step();
    chk("drain_pc1",  opc2, 32'h4);
    chk("drain_stop", 32'(stop2), 32'd0);
    step();
    chk("drain_empty", 32'(ov2), 32'd0);
    // DEPTH=4 still holds 0x8; clear everything before streaming
    drive(0, 32'h0, 32'h0, 0, 1); step();

    // Streaming 0x0..0x20
    exp_out = 32'h0;
    for (int pc = 0; pc <= 32'h20; pc += 4) begin
      drive(1, 32'(pc), ins(32'(pc)), 1, 0);
      if (ov2) begin
        chk("stream_order", opc2, exp_out);
        exp_out += 4;
      end
      step();
      chk("stream_cnt",  32'(cnt2),  32'd1);
      chk("stream_stop", 32'(stop2), 32'd0);
    end
    drive(0, 32'h0, 32'h0, 1, 0);
    if (ov2) begin
      chk("stream_order", opc2, exp_out);
      exp_out += 4;
    end
    step();
    chk("stream_total", exp_out, 32'h24);

    // Flush with simultaneous push and pop
    drive(1, 32'h10, ins(32'h10), 0, 0); step();
    drive(1, 32'h14, ins(32'h14), 0, 0); step();
    chk("pre_flush_cnt", 32'(cnt2), 32'd2);
    drive(1, 32'h18, ins(32'h18), 1, 1); step();
    chk("flush_cnt", 32'(cnt2), 32'd0);
    chk("flush_ov",  32'(ov2),  32'd0);
    drive(1, 32'h40, ins(32'h40), 0, 0); step();
    chk("post_flush_pc", opc2, 32'h40);

    // Simultaneous push/pop at count=1 on DEPTH=4
    drive(1, 32'h44, ins(32'h44), 1, 0); step();
    chk("pp4_cnt", 32'(cnt4), 32'd1);
    chk("pp4_pc",  opc4, 32'h44);

    // Reset asserted between edges
    drive(0, 32'h0, 32'h0, 0, 0);
    #2 fb_rst_n = 1'b0;
    m2.delete();
    m4.delete();
    #1;
    chk("async_ov2",  32'(ov2),  32'd0);
    chk("async_cnt2", 32'(cnt2), 32'd0);
    chk("async_cnt4", 32'(cnt4), 32'd0);
    @(posedge fb_clk);
    #1 fb_rst_n = 1'b1;
    drive(1, 32'h80, ins(32'h80), 1, 0); step();
    chk("post_rst_pc", opc2, 32'h80);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom % 4) != 0, $urandom & 32'hFFFF_FFFC, $urandom,
            ($urandom % 3) != 0, ($urandom % 25) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
